// File: rtl/dds_cfg_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dds_cfg_pkg
// Purpose  : Shared constants and types for the DDS SPI configuration block.
//            Holds the register map, CTRL bit positions, STATUS ID, frame
//            length and the SPI frame FSM state type.
// Ports    : none (package)
// Options  : DDS_CFG_READBACK_EN (used by dds_cfg_spi)
// Revision : 1.0 - initial release
// ============================================================================
package dds_cfg_pkg;

  localparam int FRAME_BITS = 40;
  localparam int CMD_BITS   = 8;
  localparam int DATA_BITS  = 32;

  localparam logic [6:0] ADDR_FREQ1  = 7'h00;
  localparam logic [6:0] ADDR_FREQ2  = 7'h01;
  localparam logic [6:0] ADDR_SYM    = 7'h02;
  localparam logic [6:0] ADDR_CTRL   = 7'h03;
  localparam logic [6:0] ADDR_STATUS = 7'h04;

  localparam int CTRL_COMMIT_BIT = 0;
  localparam int CTRL_EN_LSB     = 1;
  localparam int CTRL_EN_MSB     = 2;

  localparam logic [15:0] STATUS_ID = 16'hD5C0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_DATA = 2'd2,
    ST_DONE = 2'd3
  } spi_state_e;

endpackage
`default_nettype wire

// File: rtl/dds_cfg_spi_sync.sv
`default_nettype none
// ============================================================================
// Module   : spi_slave_sync
// Purpose  : Oversamples the SPI pins into the DDS clock domain and produces
//            single-cycle edge strobes from the synchronised sclk and cs_n.
// Ports    : clk, rst            - DDS clock, async active-high reset
//            spi_sclk/cs_n/mosi  - raw SPI pins
//            sclk_rise/sclk_fall - one-cycle strobes on synchronised sclk
//            cs_fall/cs_rise     - one-cycle strobes on synchronised cs_n
//            mosi_s              - synchronised mosi, aligned with sclk strobes
// Revision : 1.0 - initial release
// ============================================================================
module spi_slave_sync
  import dds_cfg_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic spi_sclk,
  input  logic spi_cs_n,
  input  logic spi_mosi,
  output logic sclk_rise,
  output logic sclk_fall,
  output logic cs_fall,
  output logic cs_rise,
  output logic mosi_s
);

  logic [SYNC_STAGES-1:0] sclk_q;
  logic [SYNC_STAGES-1:0] cs_n_q;
  logic [SYNC_STAGES-1:0] mosi_q;
  logic                   sclk_prev_q;
  logic                   cs_n_prev_q;

  // All three pins go through the same depth so mosi stays aligned with the
  // sclk edge that samples it. cs_n resets high (deselected).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_q      <= '0;
      cs_n_q      <= '1;
      mosi_q      <= '0;
      sclk_prev_q <= 1'b0;
      cs_n_prev_q <= 1'b1;
    end else begin
      sclk_q      <= {sclk_q[SYNC_STAGES-2:0], spi_sclk};
      cs_n_q      <= {cs_n_q[SYNC_STAGES-2:0], spi_cs_n};
      mosi_q      <= {mosi_q[SYNC_STAGES-2:0], spi_mosi};
      sclk_prev_q <= sclk_q[SYNC_STAGES-1];
      cs_n_prev_q <= cs_n_q[SYNC_STAGES-1];
    end
  end

  assign sclk_rise =  sclk_q[SYNC_STAGES-1] & ~sclk_prev_q;
  assign sclk_fall = ~sclk_q[SYNC_STAGES-1] &  sclk_prev_q;
  assign cs_fall   = ~cs_n_q[SYNC_STAGES-1] &  cs_n_prev_q;
  assign cs_rise   =  cs_n_q[SYNC_STAGES-1] & ~cs_n_prev_q;
  assign mosi_s    =  mosi_q[SYNC_STAGES-1];

endmodule
`default_nettype wire

// File: rtl/dds_cfg_spi.sv
`default_nettype none
// ============================================================================
// Module   : dds_cfg_spi
// Purpose  : SPI-slave (mode 0) configuration register file for two DDS
//            channels. Frames are 40 bits MSB first: cmd[7]=read, cmd[6:0]=
//            address, then 32 data bits. Writes land in shadow registers; a
//            CTRL write with COMMIT=1 copies every shadow to the active outputs
//            in one clk cycle and pulses cfg_stb.
// Ports    : clk, rst                   - DDS clock, async active-high reset
//            spi_sclk/cs_n/mosi/miso    - SPI slave pins (f_sclk <= f_clk/8)
//            freq_word1/2, triangle_sym - active DDS configuration words
//            dds_en                     - active channel enables, bit0 = ch1
//            cfg_stb                    - one-cycle pulse on active update
// Options  : DDS_CFG_READBACK_EN - when defined, read frames return the
//            addressed shadow (or STATUS) on spi_miso; otherwise spi_miso is
//            tied low and read frames are consumed without effect.
// Revision : 1.0 - initial release
// ============================================================================
module dds_cfg_spi #(
  parameter int              FW_W        = 32,
  parameter logic [FW_W-1:0] DEF_FREQ    = FW_W'(2147483),
  parameter logic [FW_W-1:0] DEF_SYM     = FW_W'(154748364),
  parameter int              SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            spi_sclk,
  input  logic            spi_cs_n,
  input  logic            spi_mosi,
  output logic            spi_miso,
  output logic [FW_W-1:0] freq_word1,
  output logic [FW_W-1:0] freq_word2,
  output logic [FW_W-1:0] triangle_sym,
  output logic [1:0]      dds_en,
  output logic            cfg_stb
);
  import dds_cfg_pkg::*;

  logic cs_fall, cs_rise, sclk_rise, sclk_fall, mosi_s;

  spi_slave_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk       (clk),
    .rst       (rst),
    .spi_sclk  (spi_sclk),
    .spi_cs_n  (spi_cs_n),
    .spi_mosi  (spi_mosi),
    .sclk_rise (sclk_rise),
    .sclk_fall (sclk_fall),
    .cs_fall   (cs_fall),
    .cs_rise   (cs_rise),
    .mosi_s    (mosi_s)
  );

  spi_state_e              state_q, state_d;
  logic [5:0]              cnt_q, cnt_d;
  logic [FRAME_BITS-2:0]   shreg_q, shreg_d;
  logic [FW_W-1:0]         fw1_sh_q, fw1_sh_d;
  logic [FW_W-1:0]         fw2_sh_q, fw2_sh_d;
  logic [FW_W-1:0]         sym_sh_q, sym_sh_d;
  logic [1:0]              en_sh_q, en_sh_d;
  logic                    commit_q, commit_d;
  logic [FW_W-1:0]         fw1_q, fw2_q, sym_q;
  logic [1:0]              en_q;
  logic                    stb_q;

  // Previously shifted bits plus the bit arriving on this rising edge. On the
  // 8th edge the low byte is the command; on the 40th it is the whole frame.
  logic [FRAME_BITS-1:0]   frame_w;
  logic [6:0]              waddr_w;
  logic [DATA_BITS-1:0]    wdata_w;

  assign frame_w = {shreg_q, mosi_s};
  assign waddr_w = frame_w[FRAME_BITS-2:DATA_BITS];
  assign wdata_w = frame_w[DATA_BITS-1:0];

`ifdef DDS_CFG_READBACK_EN
  logic                 rd_q, rd_d;
  logic [DATA_BITS-1:0] tx_q, tx_d;
  logic                 miso_q, miso_d;
  logic                 pending_w;
  logic [DATA_BITS-1:0] rdata_w;

  assign pending_w = (fw1_sh_q != fw1_q) | (fw2_sh_q != fw2_q) |
                     (sym_sh_q != sym_q) | (en_sh_q != en_q);

  // Address comes from the command byte completing on this edge.
  always_comb begin
    rdata_w = '0;
    case (frame_w[6:0])
      ADDR_FREQ1:  rdata_w = DATA_BITS'(fw1_sh_q);
      ADDR_FREQ2:  rdata_w = DATA_BITS'(fw2_sh_q);
      ADDR_SYM:    rdata_w = DATA_BITS'(sym_sh_q);
      ADDR_CTRL:   rdata_w = {29'b0, en_sh_q, 1'b0};
      ADDR_STATUS: rdata_w = {STATUS_ID, 15'b0, pending_w};
      default:     rdata_w = '0;
    endcase
  end

  // Raw cs_n gates miso so the line drops as soon as the master deselects.
  assign spi_miso = miso_q & ~spi_cs_n;
`else
  logic unused_sclk_fall;
  assign unused_sclk_fall = sclk_fall;
  assign spi_miso         = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shreg_d  = shreg_q;
    fw1_sh_d = fw1_sh_q;
    fw2_sh_d = fw2_sh_q;
    sym_sh_d = sym_sh_q;
    en_sh_d  = en_sh_q;
    commit_d = 1'b0;
`ifdef DDS_CFG_READBACK_EN
    rd_d     = rd_q;
    tx_d     = tx_q;
    miso_d   = miso_q;
`endif
    if (cs_rise) begin
      // Deselect aborts any frame; a partial frame never writes.
      state_d = ST_IDLE;
      cnt_d   = '0;
`ifdef DDS_CFG_READBACK_EN
      rd_d    = 1'b0;
      miso_d  = 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cs_fall) begin
            state_d = ST_CMD;
            cnt_d   = '0;
`ifdef DDS_CFG_READBACK_EN
            rd_d    = 1'b0;
`endif
          end
        end
        ST_CMD: begin
          if (sclk_rise) begin
            shreg_d = frame_w[FRAME_BITS-2:0];
            cnt_d   = cnt_q + 6'd1;
            if (cnt_q == 6'(CMD_BITS - 1)) begin
              state_d = ST_DATA;
`ifdef DDS_CFG_READBACK_EN
              rd_d = frame_w[7];
              if (frame_w[7]) begin
                tx_d = rdata_w;
              end
`endif
            end
          end
        end
        ST_DATA: begin
          if (sclk_rise) begin
            shreg_d = frame_w[FRAME_BITS-2:0];
            cnt_d   = cnt_q + 6'd1;
            if (cnt_q == 6'(FRAME_BITS - 1)) begin
              state_d = ST_DONE;
              if (!frame_w[FRAME_BITS-1]) begin
                case (waddr_w)
                  ADDR_FREQ1: fw1_sh_d = FW_W'(wdata_w);
                  ADDR_FREQ2: fw2_sh_d = FW_W'(wdata_w);
                  ADDR_SYM:   sym_sh_d = FW_W'(wdata_w);
                  ADDR_CTRL: begin
                    en_sh_d  = wdata_w[CTRL_EN_MSB:CTRL_EN_LSB];
                    commit_d = wdata_w[CTRL_COMMIT_BIT];
                  end
                  default: ;
                endcase
              end
            end
          end
`ifdef DDS_CFG_READBACK_EN
          // First falling edge in DATA is the 8th of the frame: drive bit 31.
          if (sclk_fall && rd_q) begin
            miso_d = tx_q[DATA_BITS-1];
            tx_d   = {tx_q[DATA_BITS-2:0], 1'b0};
          end
`endif
        end
        default: ; // ST_DONE: wait for cs_n to rise, ignore sclk
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      shreg_q  <= '0;
      fw1_sh_q <= DEF_FREQ;
      fw2_sh_q <= DEF_FREQ;
      sym_sh_q <= DEF_SYM;
      en_sh_q  <= 2'b11;
      commit_q <= 1'b0;
      fw1_q    <= DEF_FREQ;
      fw2_q    <= DEF_FREQ;
      sym_q    <= DEF_SYM;
      en_q     <= 2'b11;
      stb_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shreg_q  <= shreg_d;
      fw1_sh_q <= fw1_sh_d;
      fw2_sh_q <= fw2_sh_d;
      sym_sh_q <= sym_sh_d;
      en_sh_q  <= en_sh_d;
      commit_q <= commit_d;
      // commit_q rises together with the CTRL shadow update, so the enables
      // written in the committing frame are part of this copy.
      if (commit_q) begin
        fw1_q <= fw1_sh_q;
        fw2_q <= fw2_sh_q;
        sym_q <= sym_sh_q;
        en_q  <= en_sh_q;
      end
      stb_q    <= commit_q;
    end
  end

`ifdef DDS_CFG_READBACK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q   <= 1'b0;
      tx_q   <= '0;
      miso_q <= 1'b0;
    end else begin
      rd_q   <= rd_d;
      tx_q   <= tx_d;
      miso_q <= miso_d;
    end
  end
`endif

  assign freq_word1   = fw1_q;
  assign freq_word2   = fw2_q;
  assign triangle_sym = sym_q;
  assign dds_en       = en_q;
  assign cfg_stb      = stb_q;

endmodule
`default_nettype wire

// File: tb/tb_dds_cfg_spi.sv
`default_nettype none
// ============================================================================
// Module   : tb_dds_cfg_spi
// Purpose  : Directed self-checking bench for dds_cfg_spi. Drives SPI mode 0
//            frames at f_clk/8 and checks active outputs, commit strobe and
//            (when DDS_CFG_READBACK_EN is defined) readback data.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dds_cfg_spi;

  localparam logic [31:0] DEF_FREQ = 32'd2147483;
  localparam logic [31:0] DEF_SYM  = 32'd154748364;
`ifdef DDS_CFG_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  logic        clk  = 1'b0;
  logic        rst  = 1'b1;
  logic        sclk = 1'b0;
  logic        cs_n = 1'b1;
  logic        mosi = 1'b0;
  logic        miso;
  logic [31:0] fw1, fw2, sym;
  logic [1:0]  en;
  logic        stb;

  int n_cmp   = 0;
  int n_fail  = 0;
  int stb_cnt = 0;
  int bad_chg = 0;
  logic [31:0] fw1_at_stb = '0;
  logic [97:0] prev_act   = '0;
  logic [31:0] rd;

  always #5 clk = ~clk;

  dds_cfg_spi dut (
    .clk          (clk),
    .rst          (rst),
    .spi_sclk     (sclk),
    .spi_cs_n     (cs_n),
    .spi_mosi     (mosi),
    .spi_miso     (miso),
    .freq_word1   (fw1),
    .freq_word2   (fw2),
    .triangle_sym (sym),
    .dds_en       (en),
    .cfg_stb      (stb)
  );

  // Counts strobes and flags any active-register change outside a strobe.
  always @(negedge clk) begin
    if (rst) begin
      prev_act = {fw1, fw2, sym, en};
    end else begin
      if (stb) begin
        stb_cnt++;
        fw1_at_stb = fw1;
      end else if ({fw1, fw2, sym, en} != prev_act) begin
        bad_chg++;
      end
      prev_act = {fw1, fw2, sym, en};
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [39:0] mk(input logic r, input logic [6:0] a, input logic [31:0] d);
    return {r, a, d};
  endfunction

  // Clocks nbits of a frame with cs_n already low; data bits seen on miso
  // are sampled just before each rising edge from the 9th onward.
  task automatic spi_bits(input logic [39:0] tx, input int nbits, output logic [31:0] rx);
    rx = '0;
    for (int i = 0; i < nbits; i++) begin
      mosi = tx[39-i];
      repeat (4) @(negedge clk);
      if (i >= 8) rx = {rx[30:0], miso};
      sclk = 1'b1;
      repeat (4) @(negedge clk);
      sclk = 1'b0;
    end
  endtask

  task automatic spi_frame(input logic [39:0] tx, input int nbits, output logic [31:0] rx);
    @(negedge clk);
    cs_n = 1'b0;
    repeat (4) @(negedge clk);
    spi_bits(tx, nbits, rx);
    repeat (4) @(negedge clk);
    cs_n = 1'b1;
    mosi = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  initial begin
    repeat (5) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst_fw1", fw1, DEF_FREQ);
    chk("rst_fw2", fw2, DEF_FREQ);
    chk("rst_sym", sym, DEF_SYM);
    chk("rst_en", 32'(en), 32'd3);
    chk("rst_stb", 32'(stb), 32'd0);
    chk("rst_miso", 32'(miso), 32'd0);

    // Readback of reset shadows and an unmapped address
    spi_frame(mk(1'b1, 7'h02, 32'h0), 40, rd);
    chk("rd_sym_rst", rd, RB ? DEF_SYM : 32'd0);
    spi_frame(mk(1'b1, 7'h55, 32'hFFFF_FFFF), 40, rd);
    chk("rd_unmapped", rd, 32'd0);
    chk("miso_idle", 32'(miso), 32'd0);

    // FREQ1 staged, then committed with enables 11
    spi_frame(mk(1'b0, 7'h00, 32'h0A3D_70A4), 40, rd);
    chk("fw1_precommit", fw1, DEF_FREQ);
    chk("stb_none", 32'(stb_cnt), 32'd0);
    spi_frame(mk(1'b1, 7'h00, 32'h0), 40, rd);
    chk("rd_fw1_shadow", rd, RB ? 32'h0A3D_70A4 : 32'd0);
    spi_frame(mk(1'b0, 7'h03, 32'h7), 40, rd);
    chk("fw1_commit", fw1, 32'h0A3D_70A4);
    chk("fw1_at_stb", fw1_at_stb, 32'h0A3D_70A4);
    chk("stb_one", 32'(stb_cnt), 32'd1);
    chk("en_commit1", 32'(en), 32'd3);
    chk("fw2_keep", fw2, DEF_FREQ);

    // Pending flag in STATUS
    spi_frame(mk(1'b0, 7'h01, 32'h0000_1000), 40, rd);
    chk("fw2_precommit", fw2, DEF_FREQ);
    spi_frame(mk(1'b1, 7'h04, 32'h0), 40, rd);
    chk("status_pend", rd, RB ? 32'hD5C0_0001 : 32'd0);
    spi_frame(mk(1'b0, 7'h03, 32'h1), 40, rd);
    chk("fw2_commit", fw2, 32'h0000_1000);
    chk("stb_two", 32'(stb_cnt), 32'd2);
    spi_frame(mk(1'b1, 7'h04, 32'h0), 40, rd);
    chk("status_clean", rd, RB ? 32'hD5C0_0000 : 32'd0);

    // Aborted frame after 20 bits must not write; next frames decode normally
    spi_frame(mk(1'b0, 7'h00, 32'h1234_5678), 20, rd);
    spi_frame(mk(1'b0, 7'h03, 32'h3), 40, rd);
    chk("fw1_after_abort", fw1, 32'h0A3D_70A4);
    chk("en_01", 32'(en), 32'd1);
    chk("stb_three", 32'(stb_cnt), 32'd3);
    spi_frame(mk(1'b0, 7'h02, 32'h1111_1111), 40, rd);
    spi_frame(mk(1'b0, 7'h03, 32'h5), 40, rd);
    chk("sym_commit", sym, 32'h1111_1111);
    chk("en_10", 32'(en), 32'd2);
    chk("stb_four", 32'(stb_cnt), 32'd4);
    chk("no_stray_update", 32'(bad_chg), 32'd0);

    // Reset in the middle of a write frame
    @(negedge clk);
    cs_n = 1'b0;
    repeat (4) @(negedge clk);
    spi_bits(mk(1'b0, 7'h00, 32'hDEAD_BEEF), 20, rd);
    rst = 1'b1;
    #1;
    chk("mid_rst_fw1", fw1, DEF_FREQ);
    chk("mid_rst_fw2", fw2, DEF_FREQ);
    chk("mid_rst_sym", sym, DEF_SYM);
    chk("mid_rst_en", 32'(en), 32'd3);
    chk("mid_rst_stb", 32'(stb), 32'd0);
    chk("mid_rst_miso", 32'(miso), 32'd0);
    cs_n = 1'b1;
    mosi = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    spi_frame(mk(1'b0, 7'h03, 32'h1), 40, rd);
    chk("post_rst_fw1", fw1, DEF_FREQ);
    chk("post_rst_sym", sym, DEF_SYM);
    chk("stb_five", 32'(stb_cnt), 32'd5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
